// File: rtl/sing_io_ctrl.sv
// Half-duplex single-wire byte controller: arbitrates a transmitter and a receiver
// onto one tri-state pin, sending or sampling 8 bits MSB first.
module sing_io_ctrl #(
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       rx_req,
  output logic       rx_grant,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       io_i,
  output logic       io_t,
  input  logic       io_o,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, TX, TURN, RX} state_t;

  localparam logic [7:0] LP_BIT_LAST  = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] LP_SAMPLE    = 8'(BIT_CYCLES / 2);
  localparam logic [3:0] LP_TURN_LAST = 4'(TURN_CYCLES - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic       r_ioMeta;
  logic       r_ioSync;
  logic [7:0] r_bitCnt;
  logic [2:0] r_bitIdx;
  logic [3:0] r_turnCnt;
  logic [7:0] r_shift;
  logic [7:0] r_rxData;
  logic       r_lastRx;

  logic       w_bitEnd;
  logic       w_byteEnd;
  logic       w_sample;
  logic       w_turnEnd;
  logic       w_grantTx;
  logic       w_grantRx;
  logic [7:0] w_rxByte;

  assign w_bitEnd  = (r_bitCnt == LP_BIT_LAST);
  assign w_byteEnd = w_bitEnd && (r_bitIdx == 3'd7);
  assign w_sample  = (r_bitCnt == LP_SAMPLE);
  assign w_turnEnd = (r_turnCnt == LP_TURN_LAST);

  // r_lastRx set means the receiver won last, so the transmitter wins a tie
  assign w_grantTx = tx_valid && (!rx_req || r_lastRx);
  assign w_grantRx = rx_req && (!tx_valid || !r_lastRx);

  // With BIT_CYCLES=2 the final sample lands on the last RX cycle itself
  assign w_rxByte = w_sample ? {r_shift[6:0], r_ioSync} : r_shift;
  assign rx_data  = rx_valid ? w_rxByte : r_rxData;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ioMeta <= 1'b0;
      r_ioSync <= 1'b0;
    end else begin
      r_ioMeta <= io_o;
      r_ioSync <= r_ioMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bitCnt  <= 8'd0;
      r_bitIdx  <= 3'd0;
      r_turnCnt <= 4'd0;
      r_shift   <= 8'd0;
      r_rxData  <= 8'd0;
      r_lastRx  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          r_bitCnt  <= 8'd0;
          r_bitIdx  <= 3'd0;
          r_turnCnt <= 4'd0;
          if (w_grantTx) begin
            r_shift  <= tx_data;
            r_lastRx <= 1'b0;
          end else if (w_grantRx) begin
            r_shift  <= 8'd0;
            r_lastRx <= 1'b1;
          end
        end
        TX: begin
          if (w_bitEnd) begin
            r_bitCnt <= 8'd0;
            r_bitIdx <= r_bitIdx + 3'd1;
            r_shift  <= {r_shift[6:0], 1'b0};
          end else begin
            r_bitCnt <= r_bitCnt + 8'd1;
          end
        end
        TURN: r_turnCnt <= r_turnCnt + 4'd1;
        RX: begin
          if (w_sample) r_shift <= {r_shift[6:0], r_ioSync};
          if (w_bitEnd) begin
            r_bitCnt <= 8'd0;
            r_bitIdx <= r_bitIdx + 3'd1;
          end else begin
            r_bitCnt <= r_bitCnt + 8'd1;
          end
          if (w_byteEnd) r_rxData <= w_rxByte;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    tx_ready    = 1'b0;
    rx_grant    = 1'b0;
    rx_valid    = 1'b0;
    io_t        = 1'b1;
    io_i        = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_grantTx) begin
          tx_ready    = 1'b1;
          w_nextState = TX;
        end else if (w_grantRx) begin
          rx_grant    = 1'b1;
          w_nextState = RX;
        end
      end
      TX: begin
        io_t = 1'b0;
        io_i = r_shift[7];
        if (w_byteEnd) w_nextState = TURN;
      end
      TURN: if (w_turnEnd) w_nextState = IDLE;
      RX: begin
        if (w_byteEnd) begin
          rx_valid    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    // Reset forces the pin released and all pulses low in the same cycle
    if (rst) begin
      w_nextState = IDLE;
      tx_ready    = 1'b0;
      rx_grant    = 1'b0;
      rx_valid    = 1'b0;
      io_t        = 1'b1;
      io_i        = 1'b0;
      busy        = 1'b0;
    end
  end

endmodule

// File: tb/tb_sing_io_ctrl.sv
// Scoreboard bench for sing_io_ctrl: a round-robin reference model queues the expected
// transactions, a monitor decodes the pin waveform and compares; a second fast instance
// checks back-to-back spacing.
module tb_sing_io_ctrl;

  localparam int BC  = 4;
  localparam int TC  = 2;
  localparam int FBC = 2;
  localparam int FTC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst, tx_valid, tx_ready, rx_req, rx_grant, rx_valid, io_i, io_t, io_o, busy;
  logic [7:0] tx_data, rx_data;

  logic       f_rst, f_tx_valid, f_tx_ready, f_rx_req, f_rx_grant, f_rx_valid;
  logic       f_io_i, f_io_t, f_io_o, f_busy;
  logic [7:0] f_tx_data, f_rx_data;

  sing_io_ctrl #(.BIT_CYCLES(BC), .TURN_CYCLES(TC)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_grant(rx_grant), .rx_valid(rx_valid), .rx_data(rx_data),
    .io_i(io_i), .io_t(io_t), .io_o(io_o), .busy(busy)
  );

  sing_io_ctrl #(.BIT_CYCLES(FBC), .TURN_CYCLES(FTC)) u_fast (
    .clk(clk), .rst(f_rst), .tx_valid(f_tx_valid), .tx_data(f_tx_data), .tx_ready(f_tx_ready),
    .rx_req(f_rx_req), .rx_grant(f_rx_grant), .rx_valid(f_rx_valid), .rx_data(f_rx_data),
    .io_i(f_io_i), .io_t(f_io_t), .io_o(f_io_o), .busy(f_busy)
  );

  typedef struct {
    bit         isTx;
    logic [7:0] data;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] lastRxData = 8'h00;
  bit         modelLastRx = 1'b1;
  logic [7:0] rxDriveByte = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Reference model: a grant goes to the sole requester, or on a tie to the one not served last
  task automatic expectTx(input logic [7:0] d);
    exp_t e;
    e.isTx = 1'b1;
    e.data = d;
    expQ.push_back(e);
    modelLastRx = 1'b0;
  endtask

  task automatic expectRx(input logic [7:0] d);
    exp_t e;
    e.isTx = 1'b0;
    e.data = d;
    expQ.push_back(e);
    modelLastRx = 1'b1;
  endtask

  task automatic expectBoth(input logic [7:0] txb, input logic [7:0] rxb);
    if (modelLastRx) begin
      expectTx(txb);
      expectRx(rxb);
    end else begin
      expectRx(rxb);
      expectTx(txb);
    end
  endtask

  task automatic waitGrant(output bit gotTx, output bit gotRx);
    gotTx = 1'b0;
    gotRx = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready || rx_grant) begin
        gotTx = tx_ready;
        gotRx = rx_grant;
        return;
      end
    end
    failNow("grant_wait");
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    failNow("idle_wait");
  endtask

  task automatic applyStimulus(input int kind, input logic [7:0] txb, input logic [7:0] rxb);
    bit gt, gr;
    @(posedge clk);
    #1;
    rxDriveByte = rxb;
    if (kind == 0) begin
      expectTx(txb);
      tx_data  = txb;
      tx_valid = 1'b1;
      waitGrant(gt, gr);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end else if (kind == 1) begin
      expectRx(rxb);
      rx_req = 1'b1;
      waitGrant(gt, gr);
      @(posedge clk);
      #1;
      rx_req = 1'b0;
    end else begin
      expectBoth(txb, rxb);
      tx_data  = txb;
      tx_valid = 1'b1;
      rx_req   = 1'b1;
      for (int n = 0; n < 2; n++) begin
        waitGrant(gt, gr);
        @(posedge clk);
        #1;
        if (gt) begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
        if (gr) rx_req = 1'b0;
      end
      tx_valid = 1'b0;
      rx_req   = 1'b0;
    end
    waitIdle();
  endtask

  task automatic monitorTx();
    exp_t       e;
    logic [7:0] got;
    bit         tOk, holdOk, turnOk;
    checkOutput("tx_grant_exclusive", rx_grant, 1'b0);
    if (expQ.size() == 0) begin
      failNow("unexpected_tx_grant");
      return;
    end
    e = expQ.pop_front();
    checkOutput("grant_order_is_tx", e.isTx, 1'b1);
    got    = 8'h00;
    tOk    = 1'b1;
    holdOk = 1'b1;
    turnOk = 1'b1;
    for (int c = 0; c < 8 * BC; c++) begin
      @(negedge clk);
      if (rst) return;
      if (io_t !== 1'b0 || busy !== 1'b1) tOk = 1'b0;
      if (c % BC == 0) got[7 - c / BC] = io_i;
      else if (io_i !== got[7 - c / BC]) holdOk = 1'b0;
    end
    checkOutput("tx_drive_window", tOk, 1'b1);
    checkOutput("tx_bit_hold", holdOk, 1'b1);
    checkOutput("tx_byte", got, e.data);
    for (int c = 0; c < TC; c++) begin
      @(negedge clk);
      if (rst) return;
      if (io_t !== 1'b1 || io_i !== 1'b0 || busy !== 1'b1) turnOk = 1'b0;
    end
    checkOutput("turn_phase", turnOk, 1'b1);
  endtask

  task automatic monitorRx();
    exp_t e;
    int   n;
    bit   tOk;
    if (expQ.size() == 0) begin
      failNow("unexpected_rx_grant");
      return;
    end
    e = expQ.pop_front();
    checkOutput("grant_order_is_rx", e.isTx, 1'b0);
    n   = 0;
    tOk = 1'b1;
    for (int c = 0; c < 8 * BC + 8; c++) begin
      @(negedge clk);
      if (rst) return;
      n++;
      if (io_t !== 1'b1 || busy !== 1'b1) tOk = 1'b0;
      if (rx_valid) break;
    end
    checkOutput("rx_length", n, 8 * BC);
    checkOutput("rx_io_t_released", tOk, 1'b1);
    checkOutput("rx_byte", rx_data, e.data);
    lastRxData = e.data;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (tx_ready) monitorTx();
      else if (rx_grant) monitorRx();
      else begin
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_io_t", io_t, 1'b1);
        checkOutput("idle_io_i", io_i, 1'b0);
        checkOutput("idle_rx_valid", rx_valid, 1'b0);
        checkOutput("rx_data_hold", rx_data, lastRxData);
      end
    end
  end

  // Remote device: answers each receive grant with rxDriveByte, MSB first
  initial begin
    logic [7:0] b;
    io_o = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_grant && !rst) begin
        b = rxDriveByte;
        for (int k = 7; k >= 0; k--) begin
          io_o = b[k];
          repeat (BC) @(negedge clk);
        end
        io_o = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    bit gt, gr;
    int c1, n;
    bit okT, okI;
    rst        = 1'b1;
    tx_valid   = 1'b1;
    tx_data    = 8'hA5;
    rx_req     = 1'b1;
    f_rst      = 1'b1;
    f_tx_valid = 1'b0;
    f_tx_data  = 8'h00;
    f_rx_req   = 1'b0;
    f_io_o     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_io_t", io_t, 1'b1);
    checkOutput("rst_io_i", io_i, 1'b0);
    checkOutput("rst_tx_ready", tx_ready, 1'b0);
    checkOutput("rst_rx_grant", rx_grant, 1'b0);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);

    // Both requesters held high across three grants: TX first, then alternation
    rxDriveByte = 8'h3C;
    expectTx(8'hA5);
    expectRx(8'h3C);
    expectTx(8'hA5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int g = 0; g < 3; g++) waitGrant(gt, gr);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    rx_req   = 1'b0;
    waitIdle();

    for (int i = 0; i < 16; i++)
      applyStimulus(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));

    // Reset in the middle of a transmit
    @(posedge clk);
    #1;
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    expectTx(tx_data);
    waitGrant(gt, gr);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst        = 1'b1;
    lastRxData = 8'h00;
    @(negedge clk);
    checkOutput("midtx_rst_io_t", io_t, 1'b1);
    checkOutput("midtx_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    modelLastRx = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("after_tx_rst_io_t", io_t, 1'b1);
    checkOutput("after_tx_rst_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    applyStimulus(0, 8'($urandom), 8'h00);

    // Reset in the middle of a receive: partial byte dropped, no rx_valid
    @(posedge clk);
    #1;
    rxDriveByte = 8'($urandom);
    expectRx(rxDriveByte);
    rx_req = 1'b1;
    waitGrant(gt, gr);
    @(posedge clk);
    #1;
    rx_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst        = 1'b1;
    lastRxData = 8'h00;
    @(negedge clk);
    checkOutput("midrx_rst_rx_valid", rx_valid, 1'b0);
    checkOutput("midrx_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    modelLastRx = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("after_rx_rst_rx_data", rx_data, 8'h00);
    repeat (40) @(negedge clk);
    applyStimulus(2, 8'($urandom), 8'($urandom));

    // Fast instance: FF then 00 back to back
    @(posedge clk);
    #1;
    f_rst      = 1'b0;
    f_tx_valid = 1'b1;
    f_tx_data  = 8'hFF;
    c1 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (f_tx_ready) begin
        c1 = cyc;
        break;
      end
    end
    if (c1 < 0) failNow("fast_first_grant");
    @(posedge clk);
    #1;
    f_tx_data = 8'h00;
    okT = 1'b1;
    okI = 1'b1;
    n   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (f_tx_ready) begin
        n = cyc - c1;
        break;
      end
      if (f_io_t !== ((k <= 8 * FBC) ? 1'b0 : 1'b1)) okT = 1'b0;
      if (f_io_i !== ((k <= 8 * FBC) ? 1'b1 : 1'b0)) okI = 1'b0;
    end
    checkOutput("fast_grant_spacing", n, 8 * FBC + FTC + 1);
    checkOutput("fast_ff_io_t", okT, 1'b1);
    checkOutput("fast_ff_io_i", okI, 1'b1);
    @(posedge clk);
    #1;
    f_tx_valid = 1'b0;
    okT = 1'b1;
    okI = 1'b1;
    for (int k = 1; k <= 8 * FBC + FTC; k++) begin
      @(negedge clk);
      if (f_io_t !== ((k <= 8 * FBC) ? 1'b0 : 1'b1)) okT = 1'b0;
      if (f_io_i !== 1'b0 || f_busy !== 1'b1) okI = 1'b0;
    end
    checkOutput("fast_00_io_t", okT, 1'b1);
    checkOutput("fast_00_io_i", okI, 1'b1);
    @(negedge clk);
    checkOutput("fast_idle_busy", f_busy, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drain", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sing_io_ctrl.md
SING_IO_CTRL -- requirements
Module: sing_io_ctrl

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4, clock cycles per serial bit (legal values 2..255).
REQ-002 SHALL have parameter TURN_CYCLES, default 2, tri-state turnaround cycles after each transmit (legal values 1..15).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_valid  input  1  requester A holds a byte to transmit.
REQ-006 tx_data  input  8  byte to transmit; sampled on the grant cycle.
REQ-007 tx_ready  output  1  one-cycle pulse: byte accepted.
REQ-008 rx_req  input  1  requester B asks for one byte to be received.
REQ-009 rx_grant  output  1  one-cycle pulse: receive request accepted.
REQ-010 rx_valid  output  1  one-cycle pulse: rx_data holds a new byte.
REQ-011 rx_data  output  8  last received byte; held until the next rx_valid.
REQ-012 io_i  output  1  drives IOBUF I.
REQ-013 io_t  output  1  drives IOBUF T; 1 = high-Z, 0 = drive.
REQ-014 io_o  input  1  from IOBUF O; asynchronous to clk.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL pass io_o through a 2-flop synchronizer; all sampling uses the synchronized value (io_s).
REQ-017 SHALL implement FSM states IDLE, TX, TURN, RX.
REQ-018 IDLE: io_t=1, io_i=0. tx_valid only -> grant TX. rx_req only -> grant RX. Both -> grant the requester not granted last (round-robin). Neither -> stay.
REQ-019 Grant TX: tx_ready=1 for that cycle; latch tx_data into the shift register; next state TX.
REQ-020 Grant RX: rx_grant=1 for that cycle; next state RX.
REQ-021 TX: io_t=0 for exactly 8*BIT_CYCLES cycles; io_i = current bit, MSB first; each bit held BIT_CYCLES cycles; next state TURN.
REQ-022 TURN: io_t=1, io_i=0 for exactly TURN_CYCLES cycles; next state IDLE.
REQ-023 RX: io_t=1 for exactly 8*BIT_CYCLES cycles.
REQ-024 RX sampling: io_s is sampled once per bit, at bit-cycle index BIT_CYCLES/2 (integer division, index 0-based); bits shift in MSB first.
REQ-025 RX completion: on the last RX cycle, rx_data is updated and rx_valid=1 for that one cycle; next state IDLE.
REQ-026 io_t SHALL never be 0 outside TX; TX SHALL never be entered except from IDLE.
REQ-027 Requests arriving while busy are ignored until IDLE; no queuing. tx_valid/rx_req are level-sensitive and re-evaluated in IDLE.
REQ-028 tx_data changes after the grant cycle SHALL NOT affect the byte on the wire.
REQ-029 Bit and byte counters SHALL wrap cleanly; no partial bytes are emitted.
REQ-030 Back-to-back TX: minimum spacing between two TX grants is 8*BIT_CYCLES+TURN_CYCLES+1 cycles.

Reset
REQ-031 While rst=1: state=IDLE, io_t=1, io_i=0, tx_ready=0, rx_grant=0, rx_valid=0, rx_data=8'h00, busy=0, synchronizer flops=0.
REQ-032 Round-robin pointer resets to "RX last", so TX wins the first simultaneous request.
REQ-033 rst asserted mid-TX or mid-RX: outputs take reset values in the next cycle; the partial byte is discarded; no rx_valid is produced.

Verification
REQ-034 Defaults, tx_valid=1, tx_data=8'hA5 -> tx_ready pulse; io_t=0 for 32 cycles; io_i=1,0,1,0,0,1,0,1 with 4 cycles per bit; then io_t=1 for 2 cycles; then IDLE.
REQ-035 rx_req=1, io_o driven with 8'h3C MSB first at 4 cycles/bit, aligned to the rx_grant cycle plus 2 synchronizer cycles -> rx_valid pulse after 32 RX cycles with rx_data=8'h3C; io_t=1 throughout.
REQ-036 tx_valid and rx_req held high together -> grants alternate TX, RX, TX; a TURN phase follows each TX; io_t=0 only during TX.
REQ-037 rst pulsed at TX cycle 10 -> io_t=1 the next cycle; busy=0; no rx_valid; a new TX starts cleanly afterwards.
REQ-038 BIT_CYCLES=2, TURN_CYCLES=1, two back-to-back TX of 8'hFF then 8'h00 -> grant spacing of exactly 18 cycles; waveform correct.
